// File: rtl/sd_emmc_axi_wr_arbiter.sv
// Two-requester single-beat AXI write arbiter (DMA data path vs. status/descriptor writeback).
// Define AXI_WR_ARB_RR_EN for two-way round-robin; otherwise req0 has fixed priority over req1.
module sd_emmc_axi_wr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_done,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_done,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    output logic              wlast,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic              wr_err,
    input  logic              err_clr,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t state, state_nxt;
    logic   grant_go, grant_win, grant_sel;
    logic   aw_hs, w_hs, b_hs, aw_fin, w_fin;

    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    assign b_hs   = bvalid & bready;
    // a channel is finished if it handshakes now or already did earlier
    assign aw_fin = aw_hs | ~awvalid;
    assign w_fin  = w_hs | ~wvalid;
    assign busy   = (state != IDLE);

    // No grant while a done pulse is out, so a requester still holding valid is not re-served.
    assign grant_go = (state == IDLE) & (req0_valid | req1_valid) & ~(req0_done | req1_done);

`ifdef AXI_WR_ARB_RR_EN
    logic last_grant;

    assign grant_win = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

    always_ff @(posedge clock) begin
        if (!reset)        last_grant <= 1'b1;
        else if (grant_go) last_grant <= grant_win;
    end
`else
    assign grant_win = ~req0_valid;
`endif

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_go) state_nxt = XFER;
            XFER:    if (aw_fin && w_fin) state_nxt = RESP;
            RESP:    if (b_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            awaddr    <= '0;
            wdata     <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            wlast     <= 1'b0;
            bready    <= 1'b0;
            grant_sel <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            case (state)
                IDLE: if (grant_go) begin
                    awaddr    <= grant_win ? req1_addr : req0_addr;
                    wdata     <= grant_win ? req1_data : req0_data;
                    awvalid   <= 1'b1;
                    wvalid    <= 1'b1;
                    wlast     <= 1'b1;
                    grant_sel <= grant_win;
                end
                XFER: begin
                    if (aw_hs) awvalid <= 1'b0;
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        wlast  <= 1'b0;
                    end
                    if (aw_fin && w_fin) bready <= 1'b1;
                end
                RESP: if (b_hs) begin
                    bready    <= 1'b0;
                    req0_done <= ~grant_sel;
                    req1_done <= grant_sel;
                end
                default: ;
            endcase
            // an error response outranks a simultaneous clear
            if (b_hs && bresp != 2'b00) wr_err <= 1'b1;
            else if (err_clr)           wr_err <= 1'b0;
        end
    end

endmodule
